// File: rtl/cegen_pkg.sv
// rtl/cegen_pkg.sv - shared types and config check for the fractional clock-enable generator
package cegen_pkg;

   // Width of num, den and the accumulator.
   localparam int CEGEN_W = 16;

   // One channel's rate configuration: enable rate is num/den of clk.
   typedef struct packed {
      logic [CEGEN_W-1:0] num;
      logic [CEGEN_W-1:0] den;
   } cegen_cfg_t;

   // A rate is usable only if the modulus is nonzero and the rate is at most 1.
   function automatic logic cfg_valid(input logic [CEGEN_W-1:0] num,
                                      input logic [CEGEN_W-1:0] den);
      return (den != '0) && (num <= den);
   endfunction

endpackage

// File: rtl/cegen_frac_chan.sv
// rtl/cegen_frac_chan.sv - one fractional enable channel: accumulator, pending/apply, error flag
module cegen_frac_chan
   import cegen_pkg::*;
#(
   parameter logic [CEGEN_W-1:0] DEF_NUM = 1,
   parameter logic [CEGEN_W-1:0] DEF_DEN = 240
)(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_run,
   input  logic               i_resync,
   input  logic               i_load,
   input  logic [CEGEN_W-1:0] i_num,
   input  logic [CEGEN_W-1:0] i_den,
   output logic               o_cen,
   output logic               o_ce_tgl,
   output logic               o_cfg_err
);

   cegen_cfg_t         r_act;
   cegen_cfg_t         r_pcfg;
   logic               r_pend;
   logic [CEGEN_W-1:0] r_acc;
   logic               r_cen;
   logic               r_tgl;
   logic               r_err;

   cegen_cfg_t         w_pcfg;
   cegen_cfg_t         w_act_nxt;
   logic               w_load_ok;
   logic               w_pend;
   logic               w_wrap;
   logic               w_apply;
   logic [CEGEN_W:0]   w_sum;
   logic [CEGEN_W:0]   w_diff;
   logic [CEGEN_W-1:0] w_acc_nxt;

   // Next-state: accumulate, decide wrap, and fold a same-cycle load into the apply path.
   always_comb begin
      w_load_ok = i_load && cfg_valid(i_num, i_den);
      w_pcfg    = r_pcfg;
      if (w_load_ok) begin
         w_pcfg.num = i_num;
         w_pcfg.den = i_den;
      end
      w_pend = w_load_ok || r_pend;

      // W+1 bits so acc+num cannot overflow before the compare.
      w_sum  = {1'b0, r_acc} + {1'b0, r_act.num};
      w_diff = w_sum - {1'b0, r_act.den};
      w_wrap = i_run && (w_sum >= {1'b0, r_act.den});

      if (i_resync) begin
         w_acc_nxt = '0;
      end else if (i_run) begin
         w_acc_nxt = w_wrap ? w_diff[CEGEN_W-1:0] : w_sum[CEGEN_W-1:0];
      end else begin
         w_acc_nxt = r_acc;
      end

      // Swap configs only where no pulse spacing is in flight: a wrap, an idle cycle, or resync.
      w_apply   = w_pend && (i_resync || !i_run || w_wrap);
      w_act_nxt = w_apply ? w_pcfg : r_act;

      // Keep acc < den when the new modulus is smaller than the carried remainder.
      if (w_apply && (w_acc_nxt >= w_pcfg.den)) begin
         w_acc_nxt = '0;
      end
   end

   // Register all channel state; reset restores defaults and drops any pending load.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_acc      <= '0;
         r_act.num  <= DEF_NUM;
         r_act.den  <= DEF_DEN;
         r_pcfg.num <= DEF_NUM;
         r_pcfg.den <= DEF_DEN;
         r_pend     <= 1'b0;
         r_cen      <= 1'b0;
         r_tgl      <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_acc  <= w_acc_nxt;
         r_act  <= w_act_nxt;
         r_pcfg <= w_pcfg;
         r_pend <= w_pend && !w_apply;
         r_cen  <= !i_resync && w_wrap;
         r_tgl  <= i_resync ? 1'b0 : (r_tgl ^ w_wrap);
         if (i_load) begin
            r_err <= !w_load_ok;
         end
      end
   end

   assign o_cen     = r_cen;
   assign o_ce_tgl  = r_tgl;
   assign o_cfg_err = r_err;

endmodule

// File: rtl/cegen_frac.sv
// rtl/cegen_frac.sv - multi-channel fractional clock-enable generator top
module cegen_frac
   import cegen_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int W        = CEGEN_W,
   parameter int DEF_NUM  = 1,
   parameter int DEF_DEN  = 240
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [CHANNELS-1:0]   i_run,
   input  logic                  i_resync,
   input  logic [CHANNELS-1:0]   i_load,
   input  logic [CHANNELS*W-1:0] i_num,
   input  logic [CHANNELS*W-1:0] i_den,
   output logic [CHANNELS-1:0]   o_cen,
   output logic [CHANNELS-1:0]   o_ce_tgl,
   output logic [CHANNELS-1:0]   o_cfg_err
);

   // One independent channel per enable stream; resync is shared for phase alignment.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      cegen_frac_chan #(
         .DEF_NUM (CEGEN_W'(DEF_NUM)),
         .DEF_DEN (CEGEN_W'(DEF_DEN))
      ) u_chan (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_run     (i_run[gi]),
         .i_resync  (i_resync),
         .i_load    (i_load[gi]),
         .i_num     (i_num[gi*W +: W]),
         .i_den     (i_den[gi*W +: W]),
         .o_cen     (o_cen[gi]),
         .o_ce_tgl  (o_ce_tgl[gi]),
         .o_cfg_err (o_cfg_err[gi])
      );
   end

endmodule
